ulpi_reg_read: RTL and testbench

ULPI_REG_READ -- requirements
Module: ulpi_reg_read

---
 rtl/ulpi_reg_read_if.sv | 25 ++
 rtl/ulpi_reg_read.sv | 144 ++++++++++++++
 tb/tb_ulpi_reg_read.sv | 199 +++++++++++++++++++
 3 files changed

// File: rtl/ulpi_reg_read_if.sv
// ULPI register-read bundle: request/result signals plus the ULPI PHY bus pins.
// The slave modport is the reader engine; the master modport is whatever drives it.
interface ulpi_reg_read_if;
    logic       READ_DATA;
    logic [5:0] ADDR;
    logic [7:0] REG_DATA;
    logic       DONE;
    logic       ABORT;
    logic       BUSY;
    logic       DIR;
    logic       NXT;
    logic [7:0] ULPI_DATA_IN;
    logic [7:0] ULPI_DATA_OUT;
    logic       ULPI_OE;

    modport master (
        output READ_DATA, ADDR, DIR, NXT, ULPI_DATA_IN,
        input  REG_DATA, DONE, ABORT, BUSY, ULPI_DATA_OUT, ULPI_OE
    );

    modport slave (
        input  READ_DATA, ADDR, DIR, NXT, ULPI_DATA_IN,
        output REG_DATA, DONE, ABORT, BUSY, ULPI_DATA_OUT, ULPI_OE
    );
endinterface

// File: rtl/ulpi_reg_read.sv
// ULPI link-side register read engine: TXCMD, turnaround, data capture, wait for DIR low.
// Optional watchdog on TXCMD/TURN enabled by defining ULPI_READ_TIMEOUT_EN.
module ulpi_reg_read #(
    parameter logic [1:0] REG_READ_CMD   = 2'b11,
    parameter int         TIMEOUT_CYCLES = 16
) (
    input logic            clk,
    input logic            rst,
    ulpi_reg_read_if.slave bus
);

    localparam logic [2:0] IDLE     = 3'd0;
    localparam logic [2:0] TXCMD    = 3'd1;
    localparam logic [2:0] TURN     = 3'd2;
    localparam logic [2:0] RDATA    = 3'd3;
    localparam logic [2:0] WAIT_LOW = 3'd4;

    if (TIMEOUT_CYCLES < 2 || TIMEOUT_CYCLES > 255) begin : g_timeout_range_bad
        $error("ulpi_reg_read: TIMEOUT_CYCLES must be within 2..255");
    end

    logic [2:0] state_q, state_d;
    logic       oe_q, oe_d;
    logic [7:0] dout_q, dout_d;
    logic [7:0] reg_q, reg_d;
    logic       done_q, done_d;
    logic       abort_q, abort_d;
    logic       busy_q;
    logic       timeout;

`ifdef ULPI_READ_TIMEOUT_EN
    localparam logic [7:0] TO_LAST = 8'(TIMEOUT_CYCLES - 1);

    logic [7:0] cnt_q, cnt_d;

    // Counter value N means N full cycles already spent in TXCMD/TURN.
    assign timeout = (state_q == TXCMD || state_q == TURN) && (cnt_q == TO_LAST);

    always_comb begin
        cnt_d = cnt_q;
        if (state_q == IDLE)
            cnt_d = 8'd0;
        else if (state_q == TXCMD || state_q == TURN)
            cnt_d = cnt_q + 8'd1;
    end

    always_ff @(posedge clk) begin
        if (rst)
            cnt_q <= 8'd0;
        else
            cnt_q <= cnt_d;
    end
`else
    assign timeout = 1'b0;
`endif

    always_comb begin
        state_d = state_q;
        oe_d    = 1'b0;
        dout_d  = 8'd0;
        reg_d   = reg_q;
        done_d  = 1'b0;
        abort_d = 1'b0;
        case (state_q)
            IDLE: begin
                // A request while the PHY owns the bus is silently dropped.
                if (bus.READ_DATA && !bus.DIR) begin
                    state_d = TXCMD;
                    oe_d    = 1'b1;
                    dout_d  = {REG_READ_CMD, bus.ADDR};
                end
            end
            TXCMD: begin
                if (bus.DIR) begin
                    abort_d = 1'b1;
                    state_d = WAIT_LOW;
                end else if (timeout) begin
                    abort_d = 1'b1;
                    state_d = IDLE;
                end else if (bus.NXT) begin
                    state_d = TURN;
                end else begin
                    oe_d   = 1'b1;
                    dout_d = dout_q;
                end
            end
            TURN: begin
                if (bus.DIR) begin
                    state_d = RDATA;
                end else if (timeout) begin
                    abort_d = 1'b1;
                    state_d = IDLE;
                end
            end
            RDATA: begin
                if (!bus.DIR) begin
                    abort_d = 1'b1;
                    state_d = IDLE;
                end else if (bus.NXT) begin
                    // RX event from the PHY took this slot instead of our register data.
                    abort_d = 1'b1;
                    state_d = WAIT_LOW;
                end else begin
                    reg_d   = bus.ULPI_DATA_IN;
                    done_d  = 1'b1;
                    state_d = WAIT_LOW;
                end
            end
            WAIT_LOW: begin
                if (!bus.DIR)
                    state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            oe_q    <= 1'b0;
            dout_q  <= 8'd0;
            reg_q   <= 8'd0;
            done_q  <= 1'b0;
            abort_q <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            oe_q    <= oe_d;
            dout_q  <= dout_d;
            reg_q   <= reg_d;
            done_q  <= done_d;
            abort_q <= abort_d;
            busy_q  <= (state_d != IDLE);
        end
    end

    assign bus.REG_DATA      = reg_q;
    assign bus.DONE          = done_q;
    assign bus.ABORT         = abort_q;
    assign bus.BUSY          = busy_q;
    assign bus.ULPI_DATA_OUT = dout_q;
    assign bus.ULPI_OE       = oe_q;

endmodule

// File: tb/tb_ulpi_reg_read.sv
// Directed bench for ulpi_reg_read: nominal read, TXCMD/RDATA aborts, protocol error,
// reset mid-read, dropped request and the watchdog (or its absence without ULPI_READ_TIMEOUT_EN).
module tb_ulpi_reg_read;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_checks = 0;
    int   n_fail   = 0;

    ulpi_reg_read_if bus ();

    ulpi_reg_read #(.REG_READ_CMD(2'b11), .TIMEOUT_CYCLES(16)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_checks++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed 0x%02h expected 0x%02h", tag, obs, exp);
        end
    endtask

    task automatic chk_outs(input string tag, input logic oe, input logic [7:0] dout,
                            input logic [7:0] rd, input logic done, input logic abort,
                            input logic busy);
        chk({tag, ".oe"},    {7'd0, bus.ULPI_OE}, {7'd0, oe});
        chk({tag, ".dout"},  bus.ULPI_DATA_OUT, dout);
        chk({tag, ".reg"},   bus.REG_DATA, rd);
        chk({tag, ".done"},  {7'd0, bus.DONE}, {7'd0, done});
        chk({tag, ".abort"}, {7'd0, bus.ABORT}, {7'd0, abort});
        chk({tag, ".busy"},  {7'd0, bus.BUSY}, {7'd0, busy});
    endtask

    initial begin
        bit seen_abort;
        bit busy_dropped;

        bus.READ_DATA    = 1'b0;
        bus.ADDR         = 6'd0;
        bus.DIR          = 1'b0;
        bus.NXT          = 1'b0;
        bus.ULPI_DATA_IN = 8'h00;

        // Reset
        step();
        step();
        chk_outs("reset", 1'b0, 8'h00, 8'h00, 1'b0, 1'b0, 1'b0);

        // Nominal read, request on the first edge out of reset
        rst = 1'b0;
        bus.READ_DATA = 1'b1;
        bus.ADDR = 6'h16;
        step();
        chk_outs("rd1.txcmd", 1'b1, 8'hD6, 8'h00, 1'b0, 1'b0, 1'b1);
        bus.READ_DATA = 1'b0;
        bus.NXT = 1'b1;
        step();
        chk_outs("rd1.turn", 1'b0, 8'h00, 8'h00, 1'b0, 1'b0, 1'b1);
        bus.NXT = 1'b0;
        bus.DIR = 1'b1;
        bus.ULPI_DATA_IN = 8'h77;
        step();
        chk_outs("rd1.rdata", 1'b0, 8'h00, 8'h00, 1'b0, 1'b0, 1'b1);
        bus.ULPI_DATA_IN = 8'hA5;
        step();
        chk_outs("rd1.done", 1'b0, 8'h00, 8'hA5, 1'b1, 1'b0, 1'b1);
        bus.DIR = 1'b0;
        bus.ULPI_DATA_IN = 8'h00;
        step();
        chk_outs("rd1.idle", 1'b0, 8'h00, 8'hA5, 1'b0, 1'b0, 1'b0);

        // PHY grabs the bus during TXCMD; busy re-request and ADDR change ignored
        bus.READ_DATA = 1'b1;
        bus.ADDR = 6'h01;
        step();
        chk_outs("txab.txcmd", 1'b1, 8'hC1, 8'hA5, 1'b0, 1'b0, 1'b1);
        bus.ADDR = 6'h2A;
        step();
        chk_outs("txab.hold", 1'b1, 8'hC1, 8'hA5, 1'b0, 1'b0, 1'b1);
        bus.READ_DATA = 1'b0;
        bus.DIR = 1'b1;
        step();
        chk_outs("txab.abort", 1'b0, 8'h00, 8'hA5, 1'b0, 1'b1, 1'b1);
        step();
        chk_outs("txab.wait", 1'b0, 8'h00, 8'hA5, 1'b0, 1'b0, 1'b1);
        bus.DIR = 1'b0;
        step();
        chk_outs("txab.idle", 1'b0, 8'h00, 8'hA5, 1'b0, 1'b0, 1'b0);

        // RX event pre-empts the data cycle
        bus.READ_DATA = 1'b1;
        bus.ADDR = 6'h05;
        step();
        chk_outs("rxab.txcmd", 1'b1, 8'hC5, 8'hA5, 1'b0, 1'b0, 1'b1);
        bus.READ_DATA = 1'b0;
        bus.NXT = 1'b1;
        step();
        bus.NXT = 1'b0;
        bus.DIR = 1'b1;
        step();
        bus.NXT = 1'b1;
        bus.ULPI_DATA_IN = 8'h3C;
        step();
        chk_outs("rxab.abort", 1'b0, 8'h00, 8'hA5, 1'b0, 1'b1, 1'b1);
        bus.NXT = 1'b0;
        bus.DIR = 1'b0;
        step();
        chk_outs("rxab.idle", 1'b0, 8'h00, 8'hA5, 1'b0, 1'b0, 1'b0);

        // DIR drops in RDATA: protocol error straight to IDLE
        bus.READ_DATA = 1'b1;
        bus.ADDR = 6'h3F;
        step();
        chk_outs("perr.txcmd", 1'b1, 8'hFF, 8'hA5, 1'b0, 1'b0, 1'b1);
        bus.READ_DATA = 1'b0;
        bus.NXT = 1'b1;
        step();
        bus.NXT = 1'b0;
        bus.DIR = 1'b1;
        step();
        bus.DIR = 1'b0;
        bus.ULPI_DATA_IN = 8'h5A;
        step();
        chk_outs("perr.abort", 1'b0, 8'h00, 8'hA5, 1'b0, 1'b1, 1'b0);
        step();
        chk_outs("perr.quiet", 1'b0, 8'h00, 8'hA5, 1'b0, 1'b0, 1'b0);

        // Reset while in TURN
        bus.READ_DATA = 1'b1;
        bus.ADDR = 6'h10;
        step();
        bus.READ_DATA = 1'b0;
        bus.NXT = 1'b1;
        step();
        chk_outs("rstmid.turn", 1'b0, 8'h00, 8'hA5, 1'b0, 1'b0, 1'b1);
        bus.NXT = 1'b0;
        rst = 1'b1;
        step();
        chk_outs("rstmid.reset", 1'b0, 8'h00, 8'h00, 1'b0, 1'b0, 1'b0);
        rst = 1'b0;

        // Request while DIR high is dropped
        bus.DIR = 1'b1;
        bus.READ_DATA = 1'b1;
        step();
        chk_outs("drop", 1'b0, 8'h00, 8'h00, 1'b0, 1'b0, 1'b0);
        bus.READ_DATA = 1'b0;
        bus.DIR = 1'b0;
        step();
        chk_outs("drop.after", 1'b0, 8'h00, 8'h00, 1'b0, 1'b0, 1'b0);

        // PHY never answers the TXCMD
        bus.READ_DATA = 1'b1;
        bus.ADDR = 6'h00;
        step();
        chk_outs("wd.txcmd", 1'b1, 8'hC0, 8'h00, 1'b0, 1'b0, 1'b1);
        bus.READ_DATA = 1'b0;
`ifdef ULPI_READ_TIMEOUT_EN
        seen_abort = 1'b0;
        for (int i = 0; i < 15; i++) begin
            step();
            if (bus.ABORT) seen_abort = 1'b1;
        end
        chk("wd.no_early_abort", {7'd0, seen_abort}, 8'h00);
        step();
        chk_outs("wd.abort", 1'b0, 8'h00, 8'h00, 1'b0, 1'b1, 1'b0);
        step();
        chk_outs("wd.idle", 1'b0, 8'h00, 8'h00, 1'b0, 1'b0, 1'b0);
`else
        seen_abort = 1'b0;
        busy_dropped = 1'b0;
        for (int i = 0; i < 100; i++) begin
            step();
            if (bus.ABORT) seen_abort = 1'b1;
            if (!bus.BUSY) busy_dropped = 1'b1;
        end
        chk("wd.no_abort", {7'd0, seen_abort}, 8'h00);
        chk("wd.busy_held", {7'd0, busy_dropped}, 8'h00);
        chk_outs("wd.still_txcmd", 1'b1, 8'hC0, 8'h00, 1'b0, 1'b0, 1'b1);
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk_outs("wd.reset", 1'b0, 8'h00, 8'h00, 1'b0, 1'b0, 1'b0);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
